friscv_dispensador_n: RTL
=========================

Name: friscv_dispensador_n

Overview:
- N-channel successor of the Frisc-V two-pump control unit.
- Serves a queue-free, one-at-a-time pour request from any of N_SUCOS flavour buttons.
- Verifies cup presence through periodic ultrasonic measurements and doses for a programmable time.
- Pauses or aborts the pour when the cup is removed.
- Sits between the edge-detected button inputs and the sensor interface (inicia_medida / medida_pronta / medida) and drives the pump outputs.

Parameters:
- N_SUCOS, 4, number of flavours/pumps (1..8)
- T_DOSE, 50000000, pump-on cycles per complete pour
- DIST_MAX, 12'h010, BCD distance (cm) at or below which the cup counts as present
- T_REMEDIR, 5000000, cycles between re-measurements during a pour
- T_TIMEOUT, 250000000, cycles allowed in PAUSA/ESPERA before abort

Ports:
- clock in 1 system clock
- reset in 1 synchronous, active-high reset
- liga in 1 single-cycle pulse; toggles the unit on/off
- pedido in N_SUCOS single-cycle flavour request pulses (already edge-detected)
- medida_pronta in 1 single-cycle pulse; medida valid
- medida in 12 BCD distance, 3 digits, cm
- inicia_medida out 1 single-cycle pulse requesting a measurement
- ativa_bomba out N_SUCOS one-hot pump enables
- ocupado out 1 high from request accept to return to OCIOSO
- erro out 1 sticky abort flag; cleared on the next accepted request or on reset
- db_estado out 4 state code
- db_sabor out 3 index of the selected flavour

Behaviour:
- Reset: state DESLIGADO (0); all outputs 0; all counters 0.
- Clocking: all outputs registered.
- DESLIGADO (0): liga -> OCIOSO.
- Power-off: liga in any other state -> DESLIGADO next cycle, with pumps off.
- OCIOSO (1):
  - Any pedido bit -> latch the lowest set index into db_sabor, clear erro, go to MEDE.
  - Simultaneous requests: lowest index wins; the others are dropped.
- MEDE (2): inicia_medida=1 for exactly one cycle -> ESPERA (3).
- ESPERA (3):
  - On medida_pronta, compare medida as 12-bit unsigned (BCD order equals numeric order).
  - medida <= DIST_MAX -> DESPEJA.
  - Otherwise -> MEDE again.
  - The timeout counter runs from the OCIOSO exit; reaching T_TIMEOUT -> ABORTA.
- DESPEJA (4):
  - ativa_bomba[db_sabor]=1.
  - Dose counter increments each cycle.
  - Re-measure counter increments; on reaching T_REMEDIR-1 it clears and the state goes to REMEDE.
  - When the dose counter reaches T_DOSE-1 -> FIM.
- REMEDE (5):
  - Pump stays on and the dose counter keeps counting.
  - Issue inicia_medida for 1 cycle, then wait for medida_pronta.
  - Present -> DESPEJA.
  - Absent -> PAUSA.
  - Dose completion while waiting -> FIM; the late medida_pronta is ignored.
- PAUSA (6):
  - Pump off; dose counter held.
  - Timeout counter cleared on entry.
  - Re-measure every T_REMEDIR cycles (inicia_medida pulse).
  - Present -> DESPEJA, resuming the held count.
  - Timeout -> ABORTA.
- ABORTA (7): erro=1; pumps off for one cycle -> OCIOSO.
- FIM (8): pumps off for one cycle -> OCIOSO.
- ocupado=1 in states 2..8.
- pedido outside OCIOSO is ignored.
- medida_pronta outside the ESPERA/REMEDE/PAUSA waits is ignored.
- ativa_bomba is never multi-hot. It is all-zero outside DESPEJA/REMEDE.

Optional Feature:
- FRISCV_CONTADOR_DOSES_EN defined:
  - Adds output contagem [8*N_SUCOS-1:0], one 8-bit counter per flavour.
  - A counter increments on entry to FIM for that flavour and saturates at 255.
  - ABORTA does not count.
  - Counters reset to 0.
- Not defined: no contagem port, no counter logic.

Test Plan:
- Reset then liga, pedido=4'b0100, medida=12'h008 on first medida_pronta -> ativa_bomba=4'b0100 for T_DOSE cycles (bench T_DOSE=100, T_REMEDIR=30), then FIM, then OCIOSO; erro=0; db_sabor=2.
- pedido=4'b0110 in one cycle -> flavour 1 selected; the pedido=4'b0001 pulse arriving mid-pour is ignored; ativa_bomba stays 4'b0010.
- Cup removed mid-pour: medida=12'h050 at re-measure -> pump off, dose count frozen at its value. medida=12'h005 next -> pump resumes. Total pump-on cycles = T_DOSE exactly.
- Cup never returns (T_TIMEOUT=200) -> ABORTA, erro=1, pumps 0. The next pedido clears erro.
- liga pulse during DESPEJA -> DESLIGADO next cycle, ativa_bomba=0. reset asserted mid-pour -> all outputs 0 on the following edge.
- With FRISCV_CONTADOR_DOSES_EN: 3 completed pours of flavour 0 plus 1 aborted pour -> contagem[7:0]=3. 300 completed pours -> saturates at 255.

Source files
------------

// File: rtl/friscv_dispensador_n.sv
// friscv_dispensador_n: N-flavour pour controller with ultrasonic cup-presence checks.
// Define FRISCV_CONTADOR_DOSES_EN to add saturating per-flavour completed-pour counters (contagem_o).
module friscv_dispensador_n #(
  parameter int          N_SUCOS   = 4,
  parameter int          T_DOSE    = 50000000,
  parameter logic [11:0] DIST_MAX  = 12'h010,
  parameter int          T_REMEDIR = 5000000,
  parameter int          T_TIMEOUT = 250000000
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               liga_i,
  input  logic [N_SUCOS-1:0] pedido_i,
  input  logic               medida_pronta_i,
  input  logic [11:0]        medida_i,
  output logic               inicia_medida_o,
  output logic [N_SUCOS-1:0] ativa_bomba_o,
  output logic               ocupado_o,
  output logic               erro_o,
  output logic [3:0]         db_estado_o,
  output logic [2:0]         db_sabor_o
`ifdef FRISCV_CONTADOR_DOSES_EN
  ,
  output logic [8*N_SUCOS-1:0] contagem_o
`endif
);

  localparam int DW = $clog2(T_DOSE + 1);
  localparam int RW = $clog2(T_REMEDIR + 1);
  localparam int TW = $clog2(T_TIMEOUT + 1);
  localparam logic [DW-1:0] DOSE_LAST = DW'(T_DOSE - 1);
  localparam logic [RW-1:0] REM_LAST  = RW'(T_REMEDIR - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(T_TIMEOUT - 1);

  typedef enum logic [3:0] {
    DESLIGADO = 4'd0,
    OCIOSO    = 4'd1,
    MEDE      = 4'd2,
    ESPERA    = 4'd3,
    DESPEJA   = 4'd4,
    REMEDE    = 4'd5,
    PAUSA     = 4'd6,
    ABORTA    = 4'd7,
    FIM       = 4'd8
  } estado_t;

  estado_t            state_q, state_d;
  logic [2:0]         sabor_q, sabor_d, sel_s;
  logic               erro_q, erro_d;
  logic               inicia_q, inicia_d;
  logic               ocupado_q, ocupado_d;
  logic [N_SUCOS-1:0] ativa_q, ativa_d;
  logic [DW-1:0]      dose_q, dose_d;
  logic [RW-1:0]      rem_q, rem_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic               presente_s, fim_dose_s;

  assign presente_s = (medida_i <= DIST_MAX);
  assign fim_dose_s = (dose_q == DOSE_LAST);

  // Lowest requested index wins; higher simultaneous requests are dropped.
  always_comb begin
    sel_s = 3'd0;
    for (int i = N_SUCOS - 1; i >= 0; i--) begin
      if (pedido_i[i]) begin
        sel_s = 3'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    sabor_d  = sabor_q;
    erro_d   = erro_q;
    inicia_d = 1'b0;
    dose_d   = dose_q;
    rem_d    = rem_q;
    tmo_d    = tmo_q;
    if (liga_i && state_q != DESLIGADO) begin
      state_d = DESLIGADO;
    end else begin
      case (state_q)
        DESLIGADO: if (liga_i) state_d = OCIOSO;
        OCIOSO: begin
          if (|pedido_i) begin
            sabor_d  = sel_s;
            erro_d   = 1'b0;
            dose_d   = '0;
            rem_d    = '0;
            tmo_d    = '0;
            inicia_d = 1'b1;
            state_d  = MEDE;
          end
        end
        MEDE: begin
          tmo_d   = tmo_q + TW'(1);
          state_d = ESPERA;
        end
        // A present cup beats the timeout; an absent reading only retries while time remains.
        ESPERA: begin
          tmo_d = tmo_q + TW'(1);
          if (medida_pronta_i && presente_s) begin
            rem_d   = '0;
            state_d = DESPEJA;
          end else if (tmo_q >= TMO_LAST) begin
            erro_d  = 1'b1;
            state_d = ABORTA;
          end else if (medida_pronta_i) begin
            inicia_d = 1'b1;
            state_d  = MEDE;
          end
        end
        DESPEJA: begin
          dose_d = dose_q + DW'(1);
          if (fim_dose_s) begin
            state_d = FIM;
          end else if (rem_q == REM_LAST) begin
            rem_d    = '0;
            inicia_d = 1'b1;
            state_d  = REMEDE;
          end else begin
            rem_d = rem_q + RW'(1);
          end
        end
        REMEDE: begin
          dose_d = dose_q + DW'(1);
          if (fim_dose_s) begin
            state_d = FIM;
          end else if (medida_pronta_i && presente_s) begin
            rem_d   = '0;
            state_d = DESPEJA;
          end else if (medida_pronta_i) begin
            rem_d   = '0;
            tmo_d   = '0;
            state_d = PAUSA;
          end
        end
        // Dose count is held here so a resumed pour still totals T_DOSE pump cycles.
        PAUSA: begin
          tmo_d = tmo_q + TW'(1);
          if (medida_pronta_i && presente_s) begin
            rem_d   = '0;
            state_d = DESPEJA;
          end else if (tmo_q >= TMO_LAST) begin
            erro_d  = 1'b1;
            state_d = ABORTA;
          end else if (rem_q == REM_LAST) begin
            rem_d    = '0;
            inicia_d = 1'b1;
          end else begin
            rem_d = rem_q + RW'(1);
          end
        end
        ABORTA:  state_d = OCIOSO;
        FIM:     state_d = OCIOSO;
        default: state_d = DESLIGADO;
      endcase
    end
  end

  always_comb begin
    ativa_d = '0;
    for (int i = 0; i < N_SUCOS; i++) begin
      ativa_d[i] = ((state_d == DESPEJA) || (state_d == REMEDE)) && (sabor_d == 3'(i));
    end
    ocupado_d = (state_d != DESLIGADO) && (state_d != OCIOSO);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= DESLIGADO;
      sabor_q   <= 3'd0;
      erro_q    <= 1'b0;
      inicia_q  <= 1'b0;
      ocupado_q <= 1'b0;
      ativa_q   <= '0;
      dose_q    <= '0;
      rem_q     <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      sabor_q   <= sabor_d;
      erro_q    <= erro_d;
      inicia_q  <= inicia_d;
      ocupado_q <= ocupado_d;
      ativa_q   <= ativa_d;
      dose_q    <= dose_d;
      rem_q     <= rem_d;
      tmo_q     <= tmo_d;
    end
  end

  assign inicia_medida_o = inicia_q;
  assign ativa_bomba_o   = ativa_q;
  assign ocupado_o       = ocupado_q;
  assign erro_o          = erro_q;
  assign db_estado_o     = state_q;
  assign db_sabor_o      = sabor_q;

`ifdef FRISCV_CONTADOR_DOSES_EN
  logic [7:0] cnt_q [N_SUCOS];
  logic       fim_entra_s;

  assign fim_entra_s = (state_d == FIM) && (state_q != FIM);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int i = 0; i < N_SUCOS; i++) begin
        cnt_q[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < N_SUCOS; i++) begin
        if (fim_entra_s && sabor_q == 3'(i) && cnt_q[i] != 8'hFF) begin
          cnt_q[i] <= cnt_q[i] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    contagem_o = '0;
    for (int i = 0; i < N_SUCOS; i++) begin
      contagem_o[8*i +: 8] = cnt_q[i];
    end
  end
`endif

endmodule
